// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - Hamming(16,11) SECDED types, FSM states and encoder function
// Shared between this encoder engine and the program-2 decoder.
package hamming_pkg;

  typedef logic [11:1] msg_t;
  typedef logic [15:0] code_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_LO,
    ST_RD_HI,
    ST_ENC,
    ST_WR_LO,
    ST_WR_HI,
    ST_DONE
  } state_e;

  function automatic code_t hamming_encode(input msg_t d);
    logic p8, p4, p2, p1, p0;
    p8 = ^d[11:5];
    p4 = (^d[11:8]) ^ (^d[4:2]);
    p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    // p0 closes even parity over the full 16-bit word
    p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
    return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
  endfunction

endpackage

// File: rtl/hamming_enc_par.sv
// rtl/hamming_enc_par.sv - combinational 11-bit message to 16-bit SECDED codeword
module hamming_enc_par
  import hamming_pkg::*;
(
  input  logic [10:0] msg,
  output logic [15:0] code
);

  msg_t msg_w;

  assign msg_w = msg;
  assign code  = hamming_encode(msg_w);

endmodule

// File: rtl/hamming_enc_engine.sv
// rtl/hamming_enc_engine.sv - memory-to-memory Hamming encoder engine
// Reads NUM_MSG messages as byte pairs, writes each codeword back as a byte pair.
module hamming_enc_engine #(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rdata,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wdata
);
  import hamming_pkg::*;

  localparam int IDX_W = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MSG - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       lo_q, lo_d;
  logic [15:0]      cw_q, cw_d;
  logic             done_q, done_d;

  logic [10:0]       enc_msg;
  logic [15:0]       enc_code;
  logic [ADDR_W-1:0] idx_off;
  logic              unused_hi_bits;

  // The hi byte is consumed straight off the read bus in ENC; its top bits carry no data.
  assign enc_msg        = {mem_rdata[2:0], lo_q};
  assign unused_hi_bits = ^mem_rdata[7:3];
  assign idx_off        = ADDR_W'({idx_q, 1'b0});
  assign done           = done_q;

  hamming_enc_par u_par (
    .msg  (enc_msg),
    .code (enc_code)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_RD_LO;
      ST_RD_LO:         state_d = ST_RD_HI;
      ST_RD_HI:         state_d = ST_ENC;
      ST_ENC:           state_d = ST_WR_LO;
      ST_WR_LO:         state_d = ST_WR_HI;
      ST_WR_HI:         state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_RD_LO;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      ST_RD_LO: begin
        mem_rd_en = 1'b1;
        mem_addr  = ADDR_W'(SRC_BASE) + idx_off;
      end
      ST_RD_HI: begin
        mem_rd_en = 1'b1;
        mem_addr  = ADDR_W'(SRC_BASE) + idx_off + ADDR_W'(1);
      end
      ST_WR_LO: begin
        mem_wr_en = 1'b1;
        mem_addr  = ADDR_W'(DST_BASE) + idx_off;
        mem_wdata = cw_q[7:0];
      end
      ST_WR_HI: begin
        mem_wr_en = 1'b1;
        mem_addr  = ADDR_W'(DST_BASE) + idx_off + ADDR_W'(1);
        mem_wdata = cw_q[15:8];
      end
      default: ;
    endcase
  end

  // done is registered off the DONE state, so it trails the state by one edge.
  always_comb begin
    idx_d  = idx_q;
    lo_d   = lo_q;
    cw_d   = cw_q;
    done_d = (state_q == ST_DONE) && !start;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) idx_d = '0;
      ST_RD_HI:         lo_d = mem_rdata;
      ST_ENC:           cw_d = enc_code;
      ST_WR_HI:         if (idx_q != LAST_IDX) idx_d = idx_q + IDX_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      lo_q   <= '0;
      cw_q   <= '0;
      done_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      lo_q   <= lo_d;
      cw_q   <= cw_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_hamming_enc_engine.sv
// tb/tb_hamming_enc_engine.sv - self-checking bench for hamming_enc_engine
// Positional Hamming model, byte memory model and a per-cycle strobe scoreboard.
module tb_hamming_enc_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       done;
  logic [7:0] mem_addr;
  logic       mem_rd_en;
  logic [7:0] mem_rdata;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [256];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [7:0]  pre_data = '0;
  logic [7:0]  exp_rd [$];
  logic [15:0] exp_wr [$];
  logic [7:0]  exp_a;
  logic [15:0] exp_w;

  logic [10:0] msgs [15];
  logic [4:0]  junk [15];

  always #5 clk = ~clk;

  hamming_enc_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata)
  );

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Codeword bit k is Hamming position k; parity bits sit at powers of two.
  function automatic logic [15:0] model_cw(input logic [10:0] m);
    logic [15:0] cw;
    logic        x;
    int          k;
    cw = '0;
    k  = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = m[k];
        k++;
      end
    end
    for (int p = 1; p < 16; p = p * 2) begin
      x = 1'b0;
      for (int pos = 1; pos < 16; pos++)
        if ((pos & p) != 0 && pos != p) x = x ^ cw[pos];
      cw[p] = x;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  function automatic logic [12:0] model_dec(input logic [15:0] cw);
    logic [3:0]  syn;
    logic [10:0] d;
    logic [1:0]  st;
    int          k;
    syn = '0;
    d   = '0;
    k   = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if (cw[pos]) syn = syn ^ 4'(pos);
      if ((pos & (pos - 1)) != 0) begin
        d[k] = cw[pos];
        k++;
      end
    end
    if (syn == 4'd0 && !(^cw)) st = 2'b00;
    else if (^cw)              st = 2'b01;
    else                       st = 2'b10;
    return {st, d};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("strobe_overlap", 32'(mem_rd_en & mem_wr_en), 32'd0);
      chk("done_quiet", 32'(done & (mem_rd_en | mem_wr_en)), 32'd0);
      if (mem_rd_en) begin
        if (exp_rd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: got read at %0h expected no read", mem_addr);
        end else begin
          exp_a = exp_rd.pop_front();
          chk("rd_addr", 32'(mem_addr), 32'(exp_a));
        end
      end
      if (mem_wr_en) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: got write %0h@%0h expected no write", mem_wdata, mem_addr);
        end else begin
          exp_w = exp_wr.pop_front();
          chk("wr_addr_data", 32'({mem_addr, mem_wdata}), 32'(exp_w));
        end
      end
    end
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  task automatic load_run();
    logic [15:0] cw;
    for (int i = 0; i < 15; i++) begin
      poke(8'(2 * i), msgs[i][7:0]);
      poke(8'(2 * i + 1), {junk[i], msgs[i][10:8]});
    end
    for (int i = 0; i < 15; i++) begin
      cw = model_cw(msgs[i]);
      exp_rd.push_back(8'(2 * i));
      exp_rd.push_back(8'(2 * i + 1));
      exp_wr.push_back({8'(30 + 2 * i), cw[7:0]});
      exp_wr.push_back({8'(31 + 2 * i), cw[15:8]});
    end
  endtask

  task automatic do_run(input string name, input int mid_start_at);
    int edges;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({name, "_done_cleared"}, 32'(done), 32'd0);
    edges = 0;
    while (!done && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
      start = (edges == mid_start_at);
    end
    start = 1'b0;
    chk({name, "_done_edge"}, 32'(edges), 32'd76);
    chk({name, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
    chk({name, "_rd_left"}, 32'(exp_rd.size()), 32'd0);
  endtask

  task automatic scan(input string name);
    logic [15:0] cw;
    logic [12:0] dec;
    for (int i = 0; i < 15; i++) begin
      cw  = {mem[31 + 2 * i], mem[30 + 2 * i]};
      dec = model_dec(cw);
      chk({name, "_cw"}, 32'(cw), 32'(model_cw(msgs[i])));
      chk({name, "_dec_status"}, 32'(dec[12:11]), 32'd0);
      chk({name, "_dec_data"}, 32'(dec[10:0]), 32'(msgs[i]));
    end
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    chk("pin_7ff", 32'(model_cw(11'h7FF)), 32'h0000FFFF);
    chk("pin_001", 32'(model_cw(11'h001)), 32'h0000000F);
    chk("pin_400", 32'(model_cw(11'h400)), 32'h00008117);
    chk("pin_000", 32'(model_cw(11'h000)), 32'h00000000);

    for (int i = 0; i < 15; i++) begin
      msgs[i] = '0;
      junk[i] = '0;
    end
    load_run();
    do_run("zero", 0);
    for (int a = 30; a < 60; a++) chk("zero_byte", 32'(mem[a]), 32'd0);

    for (int i = 0; i < 15; i++) begin
      msgs[i] = 11'($urandom);
      junk[i] = '0;
    end
    msgs[0] = 11'h7FF;
    msgs[1] = 11'h001;
    msgs[2] = 11'h400;
    msgs[3] = 11'h2AB;
    junk[3] = 5'h1F;
    msgs[4] = 11'h2AB;
    load_run();
    do_run("directed", 0);
    chk("lit_7ff", 32'({mem[31], mem[30]}), 32'h0000FFFF);
    chk("lit_001", 32'({mem[33], mem[32]}), 32'h0000000F);
    chk("lit_400", 32'({mem[35], mem[34]}), 32'h00008117);
    chk("hi_ignored", 32'({mem[37], mem[36]}), 32'({mem[39], mem[38]}));
    scan("directed");

    for (int i = 0; i < 15; i++) begin
      msgs[i] = 11'($urandom);
      junk[i] = 5'($urandom);
    end
    load_run();
    do_run("random", 20);
    scan("random");

    for (int a = 30; a < 60; a++) poke(8'(a), 8'hA5);
    load_run();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    guard = 0;
    while (!(mem_wr_en && mem_addr == 8'd44) && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("rst_reach_msg7", 32'(guard < 200), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_rd.delete();
    exp_wr.delete();
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("midrst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("midrst_addr", 32'(mem_addr), 32'd0);
    repeat (3) @(negedge clk);
    chk("midrst_mem44", 32'(mem[44]), 32'(model_cw(msgs[7]) & 16'h00FF));
    chk("midrst_mem45", 32'(mem[45]), 32'hA5);
    chk("midrst_mem46", 32'(mem[46]), 32'hA5);
    rst_n = 1'b1;
    #1;
    load_run();
    do_run("after_rst", 33);
    scan("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
